// File: rtl/layer6_argmax.sv
// layer6_argmax: waits for the layer-6 pipeline, snapshots node outputs, scans them for the unsigned maximum.
module layer6_argmax #(
  parameter int NUM_NODES = 8,
  parameter int LATENCY = 3,
  parameter int IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [32*NUM_NODES-1:0] N_flat,
  output logic [IDX_W-1:0]        class_idx,
  output logic [31:0]             max_val,
  output logic                    valid,
  output logic                    busy
);
  localparam int CW = $clog2(LATENCY + 1) + 1;
  typedef enum logic [1:0] {IDLE, WAIT, SCAN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [IDX_W-1:0] sidx, best_idx;
  logic [31:0] best_val;
  logic [31:0] cap [NUM_NODES];
  logic grab, last, fin;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (start ? WAIT : IDLE) :
              state == WAIT ? (grab ? SCAN : WAIT) :
              state == SCAN ? (last ? DONE : SCAN) : IDLE;
  end
  always_comb begin
    grab = state == WAIT && cnt == CW'(LATENCY);
    last = state == SCAN && sidx == IDX_W'(NUM_NODES - 1);
    fin = state == DONE;
  end
  // busy stays up through the valid cycle, so it spans E0+1 .. the result edge inclusive
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      sidx <= '0;
      best_idx <= '0;
      best_val <= '0;
      class_idx <= '0;
      max_val <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
      for (int k = 0; k < NUM_NODES; k++) cap[k] <= '0;
    end else begin
      cnt <= state == IDLE ? CW'(1) : state == WAIT ? cnt + 1'b1 : cnt;
      if (grab) begin
        for (int k = 0; k < NUM_NODES; k++) cap[k] <= N_flat[32*k +: 32];
        best_val <= N_flat[31:0];
        best_idx <= '0;
        sidx <= IDX_W'(1);
      end else if (state == SCAN) begin
        if (cap[sidx] > best_val) begin
          best_val <= cap[sidx];
          best_idx <= sidx;
        end
        sidx <= sidx + 1'b1;
      end
      if (fin) begin
        class_idx <= best_idx;
        max_val <= best_val;
      end
      valid <= fin;
      busy <= state_n != IDLE || fin;
    end
  end
endmodule

// File: tb/tb_layer6_argmax.sv
// tb_layer6_argmax: directed vector table plus hand-written multi-cycle sequences for layer6_argmax.
module tb_layer6_argmax;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start_s = 1'b0;
  logic [255:0] nf = '0;
  logic [63:0] nfs = '0;
  logic [2:0] class_idx;
  logic [31:0] max_val;
  logic valid, busy;
  logic class_idx_s;
  logic [31:0] max_val_s;
  logic valid_s, busy_s;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [255:0] flat;
    logic [2:0] idx;
    logic [31:0] val;
  } vec_t;
  vec_t tbl [6];

  layer6_argmax dut (
    .clk(clk), .reset(reset), .start(start), .N_flat(nf),
    .class_idx(class_idx), .max_val(max_val), .valid(valid), .busy(busy)
  );

  layer6_argmax #(.NUM_NODES(2), .LATENCY(1), .IDX_W(1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .N_flat(nfs),
    .class_idx(class_idx_s), .max_val(max_val_s), .valid(valid_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // start sampled at E0; extra start pulses are driven so they are sampled at edges s1/s2 (relative to E0)
  task automatic run(input string nm, input logic [255:0] flat, later, input logic [2:0] ei,
                     input logic [31:0] ev, input int s1, s2, input bit tail);
    int vk, np;
    bit bz;
    start = 1'b1;
    nf = flat;
    tick();
    start = 1'b0;
    vk = 0;
    np = 0;
    bz = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (valid) begin
        np++;
        if (vk == 0) vk = k;
      end
      bz &= busy;
      if (k == 3) nf = later;
      start = (k + 1 == s1) || (k + 1 == s2);
    end
    chk({nm, "/valid_edge"}, vk, 11);
    chk({nm, "/pulses"}, np, 1);
    chk({nm, "/busy_hold"}, bz, 1);
    chk({nm, "/class_idx"}, class_idx, ei);
    chk({nm, "/max_val"}, max_val, ev);
    if (tail) begin
      tick();
      chk({nm, "/busy_fall"}, busy, 0);
      chk({nm, "/valid_fall"}, valid, 0);
    end
  endtask

  task automatic run_s(input string nm, input logic [63:0] flat, input logic ei, input logic [31:0] ev);
    int vk;
    start_s = 1'b1;
    nfs = flat;
    tick();
    start_s = 1'b0;
    vk = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (valid_s && vk == 0) vk = k;
    end
    chk({nm, "/valid_edge"}, vk, 3);
    chk({nm, "/class_idx"}, class_idx_s, ei);
    chk({nm, "/max_val"}, max_val_s, ev);
  endtask

  initial begin
    int np;
    tbl[0] = '{mk(5, 9, 2, 40, 7, 0, 1, 3), 3'd3, 32'd40};
    tbl[1] = '{mk(0, 32'hFFFF, 0, 32'hFFFF, 0, 0, 0, 0), 3'd1, 32'hFFFF};
    tbl[2] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), 3'd0, 32'd0};
    tbl[3] = '{mk(1, 1, 1, 1, 1, 1, 1, 100), 3'd7, 32'd100};
    tbl[4] = '{mk(32'h8000_0000, 32'h7FFF_FFFF, 5, 5, 5, 5, 5, 5), 3'd0, 32'h8000_0000};
    tbl[5] = '{mk(3, 3, 3, 3, 3, 3, 3, 3), 3'd0, 32'd3};
    repeat (2) tick();
    chk("reset/class_idx", class_idx, 0);
    chk("reset/max_val", max_val, 0);
    chk("reset/valid", valid, 0);
    chk("reset/busy", busy, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 6; i++)
      run($sformatf("vec%0d", i), tbl[i].flat, tbl[i].flat, tbl[i].idx, tbl[i].val, 0, 0, 1'b1);
    run("isolation", mk(1, 2, 3, 4, 5, 6, 7, 8), mk(99, 0, 0, 0, 0, 0, 0, 0), 3'd7, 32'd8, 0, 0, 1'b1);
    run("busy_start", tbl[3].flat, tbl[3].flat, 3'd7, 32'd100, 5, 11, 1'b1);
    run("chain_a", tbl[1].flat, tbl[1].flat, 3'd1, 32'hFFFF, 5, 11, 1'b0);
    run("chain_b", tbl[0].flat, tbl[0].flat, 3'd3, 32'd40, 0, 0, 1'b1);
    start = 1'b1;
    nf = tbl[3].flat;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset/class_idx", class_idx, 0);
    chk("midreset/max_val", max_val, 0);
    chk("midreset/busy", busy, 0);
    chk("midreset/valid", valid, 0);
    np = 0;
    repeat (12) begin
      tick();
      if (valid) np++;
    end
    chk("midreset/no_valid", np, 0);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("start_in_reset/busy", busy, 0);
    run("after_reset", tbl[3].flat, tbl[3].flat, 3'd7, 32'd100, 0, 0, 1'b1);
    run_s("small_a", {32'd6, 32'd7}, 1'b0, 32'd7);
    run_s("small_b", {32'd9, 32'd3}, 1'b1, 32'd9);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
